seq_mult_unit: RTL and testbench
================================

// Module: seq_mult_unit
// PURPOSE
//  Parametrised sequential shift-add multiplier: FSM control plus datapath in one block.
//  Successor to the fixed 4-bit multiplier controller. Adds:
//   - valid/ready handshakes on input and output
//   - per-operation signed/unsigned mode
//   - optional early termination once no multiplier bits remain
//  Sits between an operand producer and a result consumer in the arithmetic datapath.
// PARAMETERS
//  WIDTH      8  operand width; product is 2*WIDTH; legal range 2..32
//  EARLY_OUT  1  1: leave CALC as soon as the remaining multiplier bits are 0; 0: fixed latency
// PORTS
//  clk        in   1        clock; all state changes on the rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        operands present on md/mr/in_signed
//  in_ready   out  1        block can accept operands (high only in IDLE)
//  in_signed  in   1        1: md and mr are two's complement; 0: unsigned
//  md         in   WIDTH    multiplicand
//  mr         in   WIDTH    multiplier
//  out_valid  out  1        product valid (high only in DONE)
//  out_ready  in   1        consumer takes the product
//  product    out  2*WIDTH  result; two's complement when in_signed was 1
//  busy       out  1        high in CALC, SIGN and DONE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; busy=0; product=0; internal regs=0.
//   Reset mid-operation abandons the operation; no out_valid is produced for it.
//  Accept: on a rising edge with in_valid && in_ready. Registers on that edge:
//   - mag_md=|md|, mag_mr=|mr|; magnitude taken only if in_signed and the MSB is set.
//   - neg = in_signed & (md[W-1] ^ mr[W-1]).
//   - acc=0; cnt=0.
//   - mag_md is zero-extended to 2W bits. |-2^(W-1)| = 2^(W-1) fits in W bits unsigned.
//  States:
//   IDLE -> CALC on accept.
//   CALC, once per cycle:
//    - if mag_mr[0]: acc += mag_md (2W-bit add, no overflow possible).
//    - mag_md <<= 1; mag_mr >>= 1; cnt++.
//    - -> SIGN when cnt==WIDTH-1.
//    - -> SIGN early when EARLY_OUT=1 and the shifted mag_mr==0.
//   SIGN -> DONE: product <= neg ? -acc : acc (2W-bit two's-complement negate).
//   DONE: out_valid=1. Holds product and out_valid stable while out_ready=0.
//    - out_valid && out_ready -> IDLE; product keeps its value.
//    - in_ready returns 1 the following cycle. No same-cycle bypass of a new accept.
//  Latency, counted from the accept cycle (cycle 0):
//   - EARLY_OUT=0: CALC cycles 1..WIDTH, SIGN at WIDTH+1, out_valid at WIDTH+2.
//   - EARLY_OUT=1: out_valid at k+2, k = number of CALC cycles.
//     k = index of highest set bit of mag_mr, plus 1. mag_mr==0 still takes one CALC cycle.
//   - Minimum initiation interval: latency+1 cycles.
//  Boundary conditions:
//   - in_valid while busy: ignored; in_ready=0, so the producer must hold its operands.
//   - A zero operand yields 0 and is never negated to a non-zero value.
//   - Signed -2^(W-1) * -2^(W-1) = +2^(2W-2); it must not wrap.
// TESTING (WIDTH=8)
//  1 EARLY_OUT=0, unsigned 13*11 -> product=16'h008F; out_valid exactly 10 cycles after accept.
//  2 Signed -3*5 -> 16'hFFF1. Signed -128*-128 -> 16'h4000. Signed 127*-128 -> 16'hC080.
//  3 EARLY_OUT=1, unsigned 200*1 -> 16'h00C8 at cycle 3. 255*255 -> 16'hFE01 at cycle 10.
//  4 out_ready low 5 cycles in DONE -> product and out_valid stable, in_ready=0.
//    Then out_ready=1 -> out_valid low next cycle, in_ready high.
//  5 in_valid held high with new operands during CALC -> operands not taken.
//    They are accepted on the first IDLE cycle and yield the correct second product.
//  6 rst asserted in the 4th CALC cycle -> next cycle IDLE, out_valid=0, product=0, in_ready=1.
//    A following 6*7 -> 16'h002A.

Source files
------------

// File: rtl/seq_mult_unit.sv
// Sequential shift-add multiplier with valid/ready handshakes, per-operation
// signed/unsigned mode and optional early exit once the multiplier is exhausted.
module seq_mult_unit #(
  parameter int WIDTH     = 8,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   md,
  input  logic [WIDTH-1:0]   mr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   mag_md;
  logic [WIDTH-1:0] mag_mr;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            neg;
  logic [PW-1:0]   product_r;

  logic             accept;
  logic [WIDTH-1:0] mr_shift;
  logic             last_calc;

  // Magnitude of an operand; -2^(W-1) maps to 2^(W-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] op_mag(input logic [WIDTH-1:0] v,
                                              input logic sgn);
    logic [WIDTH-1:0] m;
    m = v;
    if (sgn && v[WIDTH-1])
      m = WIDTH'(0) - v;
    return m;
  endfunction

  // Two's-complement negate over the full product width; zero stays zero.
  function automatic logic [PW-1:0] prod_neg(input logic [PW-1:0] v);
    return PW'(0) - v;
  endfunction

  assign accept    = in_valid && (state == IDLE);
  assign mr_shift  = mag_mr >> 1;
  assign last_calc = (cnt == CW'(WIDTH - 1)) || (EARLY_OUT && (mr_shift == '0));

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (last_calc) state_nxt = SIGN;
      SIGN: state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = product_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_md    <= '0;
      mag_mr    <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      product_r <= '0;
    end else begin
      case (state)
        // Operand capture: magnitudes plus the sign of the result.
        IDLE: begin
          if (accept) begin
            mag_md <= {{WIDTH{1'b0}}, op_mag(md, in_signed)};
            mag_mr <= op_mag(mr, in_signed);
            neg    <= in_signed & (md[WIDTH-1] ^ mr[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        // One partial product per cycle; the 2W-bit accumulator cannot overflow.
        CALC: begin
          if (mag_mr[0])
            acc <= acc + mag_md;
          mag_md <= mag_md << 1;
          mag_mr <= mr_shift;
          cnt    <= cnt + CW'(1);
        end
        // Sign fix-up on the magnitude product.
        SIGN: begin
          product_r <= neg ? prod_neg(acc) : acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed bench for seq_mult_unit: one fixed-latency and one early-out instance,
// selected by 'sel', with hand-computed products and latencies.
module tb_seq_mult_unit;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_signed = 1'b0;
  logic out_ready = 1'b0;
  logic sel = 1'b0;
  logic [W-1:0] md = '0;
  logic [W-1:0] mr = '0;

  logic in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
  logic [2*W-1:0] product0, product1;
  logic in_ready, out_valid, busy;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign in_ready  = sel ? in_ready1  : in_ready0;
  assign out_valid = sel ? out_valid1 : out_valid0;
  assign busy      = sel ? busy1      : busy0;
  assign product   = sel ? product1   : product0;

  seq_mult_unit #(.WIDTH(W), .EARLY_OUT(1'b0)) u_fixed (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & ~sel), .in_ready(in_ready0), .in_signed(in_signed),
    .md(md), .mr(mr),
    .out_valid(out_valid0), .out_ready(out_ready & ~sel),
    .product(product0), .busy(busy0)
  );

  seq_mult_unit #(.WIDTH(W), .EARLY_OUT(1'b1)) u_early (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & sel), .in_ready(in_ready1), .in_signed(in_signed),
    .md(md), .mr(mr),
    .out_valid(out_valid1), .out_ready(out_ready & sel),
    .product(product1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a falling edge; leaves the DUT in its first CALC cycle.
  task automatic start(input logic s, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input string tag);
    sel = s;
    check({tag, " in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    in_signed = sgn;
    md = a;
    mr = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, input int exp_lat, input string tag);
    int cyc;
    cyc = cyc0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, cyc, exp_lat);
  endtask

  task automatic finish_op(input logic [2*W-1:0] exp, input string tag);
    check({tag, " product"}, {16'd0, product}, {16'd0, exp});
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, " in_ready_back"}, {31'd0, in_ready}, 32'd1);
    check({tag, " product_kept"}, {16'd0, product}, {16'd0, exp});
  endtask

  task automatic run_op(input logic s, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp,
                        input int lat, input string tag);
    start(s, sgn, a, b, tag);
    wait_done(1, lat, tag);
    finish_op(exp, tag);
  endtask

  initial begin
    logic saw_valid;

    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      check("rst in_ready", {31'd0, in_ready}, 32'd1);
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst product", {16'd0, product}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Fixed latency, unsigned and signed
    run_op(1'b0, 1'b0, 8'd13, 8'd11, 16'h008F, 10, "fx 13*11");
    run_op(1'b0, 1'b1, 8'hFD, 8'd5, 16'hFFF1, 10, "fx -3*5");
    run_op(1'b0, 1'b1, 8'h80, 8'h80, 16'h4000, 10, "fx -128*-128");
    run_op(1'b0, 1'b1, 8'h7F, 8'h80, 16'hC080, 10, "fx 127*-128");

    // Early-out latencies and boundaries
    run_op(1'b1, 1'b0, 8'd200, 8'd1, 16'h00C8, 3, "eo 200*1");
    run_op(1'b1, 1'b0, 8'd255, 8'd255, 16'hFE01, 10, "eo 255*255");
    run_op(1'b1, 1'b1, 8'hFB, 8'd0, 16'h0000, 3, "eo -5*0");
    run_op(1'b1, 1'b1, 8'h80, 8'h80, 16'h4000, 10, "eo -128*-128");

    // Consumer back-pressure in DONE
    start(1'b0, 1'b0, 8'd7, 8'd9, "bp");
    wait_done(1, 10, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp hold product", {16'd0, product}, 32'd63);
      check("bp hold out_valid", {31'd0, out_valid}, 32'd1);
      check("bp hold in_ready", {31'd0, in_ready}, 32'd0);
    end
    finish_op(16'd63, "bp");

    // Operands offered while busy are not taken until IDLE
    start(1'b1, 1'b0, 8'd3, 8'd5, "hold");
    in_valid = 1'b1;
    md = 8'd9;
    mr = 8'd10;
    @(negedge clk);
    check("hold in_ready_busy", {31'd0, in_ready}, 32'd0);
    wait_done(2, 5, "hold first");
    check("hold first product", {16'd0, product}, 32'd15);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold idle in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("hold second busy", {31'd0, busy}, 32'd1);
    wait_done(1, 6, "hold second");
    finish_op(16'd90, "hold second");

    // Reset in the 4th CALC cycle abandons the operation
    start(1'b1, 1'b0, 8'd255, 8'd255, "rst mid");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst mid in_ready", {31'd0, in_ready}, 32'd1);
    check("rst mid out_valid", {31'd0, out_valid}, 32'd0);
    check("rst mid product", {16'd0, product}, 32'd0);
    check("rst mid busy", {31'd0, busy}, 32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("rst mid no out_valid", {31'd0, saw_valid}, 32'd0);
    run_op(1'b1, 1'b0, 8'd6, 8'd7, 16'h002A, 5, "after rst 6*7");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
